hazard_unit_mc: RTL
===================

Name: hazard_unit_mc

Overview:
- Parametrised successor to the single-cycle load/branch hazard detector in the 5-stage pipeline; sits in ID.
- Detects RAW hazards between the ID instruction and the producers in EX and MEM.
- Drives a PC/IF-ID hold and an ID/EX bubble for a configurable number of cycles via a countdown FSM.
- Adds flush abort, register-0 masking, per-operand use qualifiers, a stall-cause code and a saturating stall-cycle counter.

Parameters:
- REG_AW, 5, register address width.
- ZERO_REG_MASK, 1, when 1 a source address of 0 never produces a hazard.
- LOAD_USE_STALLS, 1, stall cycles for a non-branch consumer of an EX-stage load; 0 disables the check; maximum 15.
- BR_ALU_STALLS, 1, stall cycles for a branch consumer of an EX-stage ALU write, and for a branch consumer of a MEM-stage load; 0 disables; maximum 15.
- BR_LOAD_STALLS, 2, stall cycles for a branch consumer of an EX-stage load; 0 disables; maximum 15.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs  in  REG_AW  ID source 1 address.
- id_rt  in  REG_AW  ID source 2 address.
- id_rs_used  in  1  source 1 is read.
- id_rt_used  in  1  source 2 is read.
- id_branch  in  1  ID instruction is a branch resolved in ID.
- ex_rd  in  REG_AW  EX destination address.
- ex_reg_write  in  1  EX instruction writes a register.
- ex_mem_read  in  1  EX instruction is a load.
- mem_rd  in  REG_AW  MEM destination address.
- mem_mem_read  in  1  MEM instruction is a load.
- flush  in  1  taken branch or exception squash.
- stall  out  1  hold PC and IF/ID.
- idex_bubble  out  1  insert NOP into ID/EX; always equal to stall.
- stall_cause  out  2  cause code: 0 none, 1 load-use, 2 branch-ALU, 3 branch-load.
- stall_count  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- hit_ex = (id_rs_used & id_rs==ex_rd & !(ZERO_REG_MASK & id_rs==0)) | (same term for id_rt). hit_mem is defined identically against mem_rd.
- Detection is combinational (Mealy); stall takes effect in the same cycle. State is held in registers: state IDLE/HOLD, cnt[3:0], cause_q.
- IDLE detection, in priority order; N is the selected stall count:
  - C3: id_branch & ex_mem_read & hit_ex; N = BR_LOAD_STALLS; cause 3.
  - C2: id_branch & ex_reg_write & !ex_mem_read & hit_ex; N = BR_ALU_STALLS; cause 2.
  - C3m: id_branch & mem_mem_read & hit_mem; N = BR_ALU_STALLS; cause 3.
  - C1: !id_branch & ex_mem_read & hit_ex; N = LOAD_USE_STALLS; cause 1.
- A case with N = 0 is skipped and the next case is tested.
- IDLE with a match:
  - stall = 1 and stall_cause = cause in the same cycle.
  - If N > 1: next state HOLD, cnt <= N-1, cause_q <= cause. Otherwise stay IDLE.
- IDLE with no match: stall = 0, stall_cause = 0.
- HOLD:
  - stall = 1 and stall_cause = cause_q regardless of the ID/EX/MEM inputs; the inputs are ignored.
  - cnt <= cnt-1; when cnt == 1, next state is IDLE.
- Return to IDLE: detection is re-evaluated in the first IDLE cycle, so back-to-back stalls are legal.
- Total stall for the C3 default is exactly 2 consecutive cycles, even though the load has moved to MEM by the second cycle.
- flush has priority over everything, in IDLE or HOLD:
  - stall = 0 and stall_cause = 0 in that cycle.
  - Next state IDLE, cnt <= 0, cause_q <= 0.
- stall_count increments by 1 on each rising edge where stall = 1. It saturates at all-ones and does not wrap.
- Reset (rst high at an edge):
  - State IDLE, cnt = 0, cause_q = 0, stall_count = 0.
  - While rst is high, stall, idex_bubble and stall_cause are forced to 0.
  - Reset during HOLD aborts the hold.
- Simultaneous rst and flush: rst wins; the result is identical to reset alone.

Test Plan:
1. Load-use: ex_mem_read=1, ex_rd=5, id_rs=5, id_rs_used=1, id_branch=0 -> stall=1 and cause=1 for 1 cycle; then, with the load in MEM, stall=0; stall_count=1.
2. Branch after load: id_branch=1, ex_mem_read=1, ex_rd=7=id_rt, id_rt_used=1; drive a non-matching ex_rd/mem_rd in cycle 2 -> stall=1 and cause=3 for exactly 2 cycles, then 0; stall_count=2.
3. Branch after ALU op: id_branch=1, ex_reg_write=1, ex_rd=3=id_rs -> stall 1 cycle, cause=2. Repeat with id_rs=0, ex_rd=0 -> no stall (zero mask).
4. Flush mid-hold: start scenario 2 and assert flush in cycle 2 -> stall=0 in that cycle and afterwards, FSM in IDLE, stall_count=1.
5. Parameter sweep: BR_LOAD_STALLS=4 -> 4-cycle stall. LOAD_USE_STALLS=0 -> scenario 1 gives no stall. Unused operand (id_rs_used=0) with a matching address -> no stall.
6. Reset mid-hold and saturation: rst in cycle 1 of a 2-cycle hold -> all outputs 0 next cycle. Separately, CNT_W=3 with 10 stalled cycles -> stall_count=7.

Source files
------------

// File: rtl/hazard_unit_mc_if.sv
// hazard_unit_mc_if: ID-stage operand, producer and stall signals of the hazard unit
interface hazard_unit_mc_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] id_rs, id_rt, ex_rd, mem_rd;
  logic              id_rs_used, id_rt_used, id_branch;
  logic              ex_reg_write, ex_mem_read, mem_mem_read, flush;
  logic              stall, idex_bubble;
  logic [1:0]        stall_cause;
  logic [CNT_W-1:0]  stall_count;
  modport master (
    output id_rs, id_rt, id_rs_used, id_rt_used, id_branch, ex_rd, ex_reg_write,
           ex_mem_read, mem_rd, mem_mem_read, flush,
    input  stall, idex_bubble, stall_cause, stall_count
  );
  modport slave (
    input  id_rs, id_rt, id_rs_used, id_rt_used, id_branch, ex_rd, ex_reg_write,
           ex_mem_read, mem_rd, mem_mem_read, flush,
    output stall, idex_bubble, stall_cause, stall_count
  );
endinterface

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: RAW hazard detector with multi-cycle countdown stall, flush abort and stall counter
module hazard_unit_mc #(
  parameter int REG_AW          = 5,
  parameter bit ZERO_REG_MASK   = 1'b1,
  parameter int LOAD_USE_STALLS = 1,
  parameter int BR_ALU_STALLS   = 1,
  parameter int BR_LOAD_STALLS  = 2,
  parameter int CNT_W           = 16
) (
  input logic             clk,
  input logic             rst,
  hazard_unit_mc_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  localparam logic [3:0] LU_N = 4'(LOAD_USE_STALLS);
  localparam logic [3:0] BA_N = 4'(BR_ALU_STALLS);
  localparam logic [3:0] BL_N = 4'(BR_LOAD_STALLS);
  logic [0:0]       r_state;
  logic [3:0]       r_cnt;
  logic [1:0]       r_cause;
  logic [CNT_W-1:0] r_count;
  logic             w_hit_ex, w_hit_mem, w_c3, w_c2, w_c3m, w_c1, w_match, w_active, w_stall;
  logic [3:0]       w_n;
  logic [1:0]       w_cause;
  function automatic logic hit(input logic [REG_AW-1:0] a, input logic u, input logic [REG_AW-1:0] rd);
    return u && a == rd && !(ZERO_REG_MASK && a == '0);
  endfunction
  assign w_hit_ex  = hit(bus.id_rs, bus.id_rs_used, bus.ex_rd) || hit(bus.id_rt, bus.id_rt_used, bus.ex_rd);
  assign w_hit_mem = hit(bus.id_rs, bus.id_rs_used, bus.mem_rd) || hit(bus.id_rt, bus.id_rt_used, bus.mem_rd);
  // A case configured for zero stall cycles drops out so the next case can match
  assign w_c3  = BL_N != 4'd0 && bus.id_branch && bus.ex_mem_read && w_hit_ex;
  assign w_c2  = BA_N != 4'd0 && bus.id_branch && bus.ex_reg_write && !bus.ex_mem_read && w_hit_ex;
  assign w_c3m = BA_N != 4'd0 && bus.id_branch && bus.mem_mem_read && w_hit_mem;
  assign w_c1  = LU_N != 4'd0 && !bus.id_branch && bus.ex_mem_read && w_hit_ex;
  assign w_match  = w_c3 || w_c2 || w_c3m || w_c1;
  assign w_active = !rst && !bus.flush;
  assign w_stall  = w_active && (r_state == HOLD || w_match);
  always_comb begin
    w_n     = w_c3 ? BL_N : (w_c2 || w_c3m) ? BA_N : w_c1 ? LU_N : 4'd0;
    w_cause = w_c3 ? 2'd3 : w_c2 ? 2'd2 : w_c3m ? 2'd3 : w_c1 ? 2'd1 : 2'd0;
  end
  assign bus.stall       = w_stall;
  assign bus.idex_bubble = w_stall;
  assign bus.stall_cause = !w_active ? 2'd0 : r_state == HOLD ? r_cause : w_cause;
  assign bus.stall_count = r_count;
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_cause <= 2'd0;
    end else if (r_state == HOLD) begin
      r_cnt <= r_cnt - 4'd1;
      if (r_cnt == 4'd1) r_state <= IDLE;
    end else if (w_match && w_n > 4'd1) begin
      r_state <= HOLD;
      r_cnt   <= w_n - 4'd1;
      r_cause <= w_cause;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) r_count <= '0;
    else if (w_stall && r_count != '1) r_count <= r_count + CNT_W'(1);
  end
endmodule
